// File: rtl/comm_pkg.sv
// Shared message-type codes and framing constants for the comm_clk UART link.
package comm_pkg;

  localparam logic [7:0] MSG_INFO        = 8'd0;
  localparam logic [7:0] MSG_INVALID     = 8'd1;
  localparam logic [7:0] MSG_NONCE_FOUND = 8'd2;

  localparam int HDR_LEN     = 4;
  localparam int MIN_PKT_LEN = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HDR  = 2'd1,
    ST_PAY  = 2'd2
  } tx_state_e;

  // A request length is framed as-is only if it covers the minimum packet and fits the payload buffer.
  function automatic logic len_in_range(input logic [7:0] len, input int max_payload);
    return (int'(len) >= MIN_PKT_LEN) && (int'(len) <= max_payload + HDR_LEN);
  endfunction

endpackage

// File: rtl/nonce_fifo.sv
// Synchronous FIFO holding golden nonces until the framer is free; pop-while-full frees a slot for a same-cycle push.
module nonce_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             pop,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty,
  output logic             drop
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign drop    = push && full && !do_pop;
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= wr_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_msg_tx.sv
// Outbound packet framer: turns parser responses and queued golden nonces into
// [len][00][00][type][payload LSB first] byte streams for the UART TX FIFO.
module uart_msg_tx
  import comm_pkg::*;
#(
  parameter int MAX_PAYLOAD = 60,
  parameter int NONCE_DEPTH = 4
) (
  input  logic                     comm_clk,
  input  logic                     reset,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [7:0]               req_type,
  input  logic [7:0]               req_len,
  input  logic [MAX_PAYLOAD*8-1:0] req_payload,
  input  logic                     nonce_valid,
  input  logic [31:0]              nonce,
  output logic                     nonce_overflow,
  input  logic                     tx_busy,
  output logic                     tx_we,
  output logic [7:0]               tx_data,
  output logic [1:0]               state_dbg
);

  localparam int PW = MAX_PAYLOAD * 8;

  tx_state_e     state;
  logic [7:0]    cnt;
  logic [7:0]    len_q;
  logic [7:0]    type_q;
  logic [PW-1:0] shift_q;
  logic [7:0]    cur_byte;
  logic [31:0]   fifo_rd;
  logic          fifo_full;
  logic          fifo_empty;
  logic          fifo_drop;
  logic          accept;
  logic          pop;
  logic          issue;

  // Handshakes: a request transfers on a cycle with req_valid && req_ready; a byte
  // transfers on a cycle with tx_we, which is only raised while tx_busy is low.
  assign req_ready = (state == ST_IDLE) && !reset;
  assign accept    = req_ready && req_valid;
  assign pop       = req_ready && !req_valid && !fifo_empty;
  assign issue     = (state != ST_IDLE) && !tx_busy && !reset;
  assign tx_we     = issue;
  assign tx_data   = issue ? cur_byte : 8'h00;
  assign state_dbg = state;

  always_comb begin
    cur_byte = shift_q[7:0];
    if (state == ST_HDR) begin
      case (cnt[1:0])
        2'd0:    cur_byte = len_q;
        2'd3:    cur_byte = type_q;
        default: cur_byte = 8'h00;
      endcase
    end
  end

  nonce_fifo #(
    .WIDTH(32),
    .DEPTH(NONCE_DEPTH)
  ) u_nonce_fifo (
    .clk    (comm_clk),
    .reset  (reset),
    .push   (nonce_valid),
    .wr_data(nonce),
    .pop    (pop),
    .rd_data(fifo_rd),
    .full   (fifo_full),
    .empty  (fifo_empty),
    .drop   (fifo_drop)
  );

  // cnt runs across header and payload, so the last byte is simply cnt == len-1.
  always_ff @(posedge comm_clk) begin
    if (reset) begin
      state          <= ST_IDLE;
      cnt            <= 8'd0;
      len_q          <= 8'd0;
      type_q         <= 8'd0;
      shift_q        <= '0;
      nonce_overflow <= 1'b0;
    end else begin
      if (fifo_drop) nonce_overflow <= 1'b1;
      case (state)
        ST_IDLE: begin
          cnt <= 8'd0;
          if (accept) begin
            state <= ST_HDR;
            if (len_in_range(req_len, MAX_PAYLOAD)) begin
              len_q   <= req_len;
              type_q  <= req_type;
              shift_q <= req_payload;
            end else begin
              len_q   <= 8'(MIN_PKT_LEN);
              type_q  <= MSG_INVALID;
              shift_q <= '0;
            end
          end else if (pop) begin
            state   <= ST_HDR;
            len_q   <= 8'(MIN_PKT_LEN);
            type_q  <= MSG_NONCE_FOUND;
            shift_q <= {{(PW-32){1'b0}}, fifo_rd};
          end
        end
        ST_HDR: begin
          if (issue) begin
            cnt <= cnt + 8'd1;
            if (cnt == 8'(HDR_LEN - 1)) state <= ST_PAY;
          end
        end
        ST_PAY: begin
          if (issue) begin
            cnt     <= cnt + 8'd1;
            shift_q <= shift_q >> 8;
            if (cnt == len_q - 8'd1) state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_msg_tx.sv
// Bench for uart_msg_tx: byte streams are compared against frames built from message-level rules.
module tb_uart_msg_tx;
  import comm_pkg::*;

  localparam int MAX_PAYLOAD = 60;
  localparam int NONCE_DEPTH = 4;
  localparam int PW          = MAX_PAYLOAD * 8;

  logic          comm_clk = 1'b0;
  logic          reset;
  logic          req_valid;
  logic          req_ready;
  logic [7:0]    req_type;
  logic [7:0]    req_len;
  logic [PW-1:0] req_payload;
  logic          nonce_valid;
  logic [31:0]   nonce;
  logic          nonce_overflow;
  logic          tx_busy;
  logic          tx_we;
  logic [7:0]    tx_data;
  logic [1:0]    state_dbg;

  int cyc = 0;
  int tests = 0;
  int fails = 0;
  int busy_mode = 0;
  logic [7:0] got_q[$];
  int         got_cyc[$];
  logic [7:0] exp_q[$];

  uart_msg_tx #(
    .MAX_PAYLOAD(MAX_PAYLOAD),
    .NONCE_DEPTH(NONCE_DEPTH)
  ) dut (
    .comm_clk      (comm_clk),
    .reset         (reset),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_type      (req_type),
    .req_len       (req_len),
    .req_payload   (req_payload),
    .nonce_valid   (nonce_valid),
    .nonce         (nonce),
    .nonce_overflow(nonce_overflow),
    .tx_busy       (tx_busy),
    .tx_we         (tx_we),
    .tx_data       (tx_data),
    .state_dbg     (state_dbg)
  );

  // Clock, cycle counter and byte capture
  always #5 comm_clk = ~comm_clk;
  always @(posedge comm_clk) cyc <= cyc + 1;
  always @(negedge comm_clk) begin
    if (tx_we === 1'b1) begin
      got_q.push_back(tx_data);
      got_cyc.push_back(cyc);
    end
  end

  // Driver tasks
  task automatic step();
    @(posedge comm_clk);
    #1;
    case (busy_mode)
      1:       tx_busy = 1'($urandom_range(0, 1));
      2:       tx_busy = ~tx_busy;
      default: ;
    endcase
  endtask

  task automatic clear_q();
    got_q.delete();
    got_cyc.delete();
    exp_q.delete();
  endtask

  task automatic send_req(input logic [7:0] t, input logic [7:0] l, input logic [PW-1:0] p,
                          output int acc);
    req_type    = t;
    req_len     = l;
    req_payload = p;
    req_valid   = 1'b1;
    acc = -1;
    for (int k = 0; k < 400; k++) begin
      if (req_ready === 1'b1) begin
        acc = cyc;
        break;
      end
      step();
    end
    step();
    req_valid = 1'b0;
  endtask

  task automatic strobe_nonce(input logic [31:0] n);
    nonce       = n;
    nonce_valid = 1'b1;
    step();
    nonce_valid = 1'b0;
  endtask

  task automatic wait_bytes(input int n, input int budget);
    for (int k = 0; k < budget && got_q.size() < n; k++) step();
    repeat (12) step();
  endtask

  // Reference model: the frame a message should produce on the wire
  function automatic void add_frame(input logic [7:0] typ, input logic [7:0] len,
                                    input logic [PW-1:0] pay);
    logic [7:0]    l;
    logic [7:0]    t;
    logic [PW-1:0] p;
    if (int'(len) < 8 || int'(len) > MAX_PAYLOAD + 4) begin
      l = 8'd8;
      t = 8'd1;
      p = '0;
    end else begin
      l = len;
      t = typ;
      p = pay;
    end
    exp_q.push_back(l);
    exp_q.push_back(8'h00);
    exp_q.push_back(8'h00);
    exp_q.push_back(t);
    for (int i = 0; i < int'(l) - 4; i++) exp_q.push_back(p[i*8 +: 8]);
  endfunction

  function automatic logic [PW-1:0] rand_payload();
    logic [PW-1:0] r;
    for (int i = 0; i < PW / 32; i++) r[i*32 +: 32] = $urandom();
    return r;
  endfunction

  function automatic logic [PW-1:0] nonce_payload(input logic [31:0] n);
    return {{(PW-32){1'b0}}, n};
  endfunction

  // Scenarios
  task automatic test_reset();
    reset = 1'b1;
    repeat (3) step();
    @(negedge comm_clk);
    tests++; if (tx_we !== 1'b0) begin fails++; $display("FAIL rst_tx_we got %b exp 0", tx_we); end
    tests++; if (tx_data !== 8'h00) begin fails++; $display("FAIL rst_tx_data got %02h exp 00", tx_data); end
    tests++; if (req_ready !== 1'b0) begin fails++; $display("FAIL rst_req_ready got %b exp 0", req_ready); end
    tests++; if (nonce_overflow !== 1'b0) begin fails++; $display("FAIL rst_overflow got %b exp 0", nonce_overflow); end
    step();
    reset = 1'b0;
    @(negedge comm_clk);
    tests++; if (req_ready !== 1'b1) begin fails++; $display("FAIL rst_ready_after got %b exp 1", req_ready); end
    clear_q();
    repeat (10) step();
    tests++; if (got_q.size() !== 0) begin fails++; $display("FAIL rst_no_bytes got %0d exp 0", got_q.size()); end
  endtask

  task automatic test_info();
    int acc;
    logic [PW-1:0] p;
    clear_q();
    p = {{(PW-64){1'b0}}, 64'hDEADBEEF13370D13};
    add_frame(MSG_INFO, 8'd16, p);
    send_req(MSG_INFO, 8'd16, p, acc);
    wait_bytes(exp_q.size(), 100);
    tests++; if (got_q.size() !== exp_q.size()) begin fails++; $display("FAIL info_count got %0d exp %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      tests++; if (got_q[i] !== exp_q[i]) begin fails++; $display("FAIL info_byte%0d got %02h exp %02h", i, got_q[i], exp_q[i]); end
      tests++; if (got_cyc[i] !== acc + 1 + i) begin fails++; $display("FAIL info_cycle%0d got %0d exp %0d", i, got_cyc[i], acc + 1 + i); end
    end
  endtask

  task automatic test_nonce();
    int p;
    clear_q();
    add_frame(MSG_NONCE_FOUND, 8'd8, nonce_payload(32'h12345678));
    p = cyc;
    strobe_nonce(32'h12345678);
    wait_bytes(exp_q.size(), 60);
    tests++; if (got_q.size() !== exp_q.size()) begin fails++; $display("FAIL nonce_count got %0d exp %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      tests++; if (got_q[i] !== exp_q[i]) begin fails++; $display("FAIL nonce_byte%0d got %02h exp %02h", i, got_q[i], exp_q[i]); end
      tests++; if (got_cyc[i] !== p + 2 + i) begin fails++; $display("FAIL nonce_cycle%0d got %0d exp %0d", i, got_cyc[i], p + 2 + i); end
    end
  endtask

  task automatic test_priority();
    int acc;
    int x;
    int l;
    logic [7:0] t;
    logic [31:0] n;
    logic [PW-1:0] p;
    clear_q();
    l = $urandom_range(8, MAX_PAYLOAD + 4);
    t = 8'($urandom_range(0, 255));
    p = rand_payload();
    n = $urandom();
    add_frame(t, 8'(l), p);
    add_frame(MSG_NONCE_FOUND, 8'd8, nonce_payload(n));
    x = cyc;
    strobe_nonce(n);
    send_req(t, 8'(l), p, acc);
    tests++; if (acc !== x + 1) begin fails++; $display("FAIL prio_accept got %0d exp %0d", acc, x + 1); end
    wait_bytes(exp_q.size(), 200);
    tests++; if (got_q.size() !== exp_q.size()) begin fails++; $display("FAIL prio_count got %0d exp %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      tests++; if (got_q[i] !== exp_q[i]) begin fails++; $display("FAIL prio_byte%0d got %02h exp %02h", i, got_q[i], exp_q[i]); end
    end
    if (got_cyc.size() > l) begin
      tests++; if (got_cyc[l] !== got_cyc[l-1] + 2) begin fails++; $display("FAIL prio_gap got %0d exp %0d", got_cyc[l] - got_cyc[l-1], 2); end
    end
  endtask

  task automatic test_invalid_len();
    int acc;
    logic [7:0] lens [7];
    logic [7:0] t;
    logic [PW-1:0] p;
    lens = '{8'd5, 8'd7, 8'd0, 8'd65, 8'd255, 8'd8, 8'd64};
    for (int j = 0; j < 7; j++) begin
      clear_q();
      t = 8'($urandom_range(0, 255));
      p = rand_payload();
      add_frame(t, lens[j], p);
      send_req(t, lens[j], p, acc);
      wait_bytes(exp_q.size(), 200);
      tests++; if (got_q.size() !== exp_q.size()) begin fails++; $display("FAIL len%0d_count got %0d exp %0d", lens[j], got_q.size(), exp_q.size()); end
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
        tests++; if (got_q[i] !== exp_q[i]) begin fails++; $display("FAIL len%0d_byte%0d got %02h exp %02h", lens[j], i, got_q[i], exp_q[i]); end
      end
    end
  endtask

  task automatic test_random();
    int acc;
    logic [7:0] l;
    logic [7:0] t;
    logic [31:0] n;
    logic [PW-1:0] p;
    busy_mode = 1;
    for (int j = 0; j < 8; j++) begin
      clear_q();
      l = 8'($urandom_range(0, 70));
      t = 8'($urandom_range(0, 255));
      p = rand_payload();
      add_frame(t, l, p);
      send_req(t, l, p, acc);
      if ($urandom_range(0, 1) == 1) begin
        n = $urandom();
        add_frame(MSG_NONCE_FOUND, 8'd8, nonce_payload(n));
        strobe_nonce(n);
      end
      wait_bytes(exp_q.size(), 600);
      tests++; if (got_q.size() !== exp_q.size()) begin fails++; $display("FAIL rand%0d_count got %0d exp %0d", j, got_q.size(), exp_q.size()); end
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
        tests++; if (got_q[i] !== exp_q[i]) begin fails++; $display("FAIL rand%0d_byte%0d got %02h exp %02h", j, i, got_q[i], exp_q[i]); end
      end
    end
    busy_mode = 0;
    tx_busy = 1'b0;
  endtask

  task automatic test_full_pop();
    int acc;
    logic [7:0] t;
    logic [31:0] n;
    logic [PW-1:0] p;
    clear_q();
    tx_busy = 1'b1;
    t = 8'($urandom_range(0, 255));
    p = rand_payload();
    add_frame(t, 8'd8, p);
    send_req(t, 8'd8, p, acc);
    for (int i = 0; i < NONCE_DEPTH; i++) begin
      n = $urandom();
      add_frame(MSG_NONCE_FOUND, 8'd8, nonce_payload(n));
      strobe_nonce(n);
    end
    tx_busy = 1'b0;
    for (int k = 0; k < 100; k++) begin
      step();
      if (req_ready === 1'b1) break;
    end
    n = $urandom();
    add_frame(MSG_NONCE_FOUND, 8'd8, nonce_payload(n));
    strobe_nonce(n);
    wait_bytes(exp_q.size(), 300);
    tests++; if (nonce_overflow !== 1'b0) begin fails++; $display("FAIL fullpop_overflow got %b exp 0", nonce_overflow); end
    tests++; if (got_q.size() !== exp_q.size()) begin fails++; $display("FAIL fullpop_count got %0d exp %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      tests++; if (got_q[i] !== exp_q[i]) begin fails++; $display("FAIL fullpop_byte%0d got %02h exp %02h", i, got_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_overflow();
    int acc;
    logic [7:0] t;
    logic [31:0] n;
    logic [PW-1:0] p;
    clear_q();
    tx_busy = 1'b1;
    t = 8'($urandom_range(0, 255));
    p = rand_payload();
    add_frame(t, 8'd8, p);
    send_req(t, 8'd8, p, acc);
    for (int i = 0; i < NONCE_DEPTH + 1; i++) begin
      n = $urandom();
      if (i < NONCE_DEPTH) add_frame(MSG_NONCE_FOUND, 8'd8, nonce_payload(n));
      strobe_nonce(n);
      if (i == NONCE_DEPTH - 1) begin
        @(negedge comm_clk);
        tests++; if (nonce_overflow !== 1'b0) begin fails++; $display("FAIL ovf_at_full got %b exp 0", nonce_overflow); end
      end
    end
    @(negedge comm_clk);
    tests++; if (nonce_overflow !== 1'b1) begin fails++; $display("FAIL ovf_set got %b exp 1", nonce_overflow); end
    step();
    tx_busy = 1'b0;
    wait_bytes(exp_q.size(), 300);
    tests++; if (nonce_overflow !== 1'b1) begin fails++; $display("FAIL ovf_sticky got %b exp 1", nonce_overflow); end
    tests++; if (got_q.size() !== exp_q.size()) begin fails++; $display("FAIL ovf_count got %0d exp %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      tests++; if (got_q[i] !== exp_q[i]) begin fails++; $display("FAIL ovf_byte%0d got %02h exp %02h", i, got_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_stall_reset();
    int acc;
    logic [PW-1:0] p;
    clear_q();
    p = rand_payload();
    add_frame(MSG_INFO, 8'd16, p);
    tx_busy = 1'b0;
    busy_mode = 2;
    send_req(MSG_INFO, 8'd16, p, acc);
    for (int k = 0; k < 200; k++) begin
      if (got_q.size() >= 6) break;
      step();
    end
    reset = 1'b1;
    busy_mode = 0;
    @(negedge comm_clk);
    tests++; if (tx_we !== 1'b0) begin fails++; $display("FAIL sr_tx_we_reset got %b exp 0", tx_we); end
    tests++; if (tx_data !== 8'h00) begin fails++; $display("FAIL sr_tx_data_reset got %02h exp 00", tx_data); end
    step();
    tx_busy = 1'b0;
    step();
    reset = 1'b0;
    @(negedge comm_clk);
    tests++; if (req_ready !== 1'b1) begin fails++; $display("FAIL sr_req_ready got %b exp 1", req_ready); end
    tests++; if (nonce_overflow !== 1'b0) begin fails++; $display("FAIL sr_overflow_cleared got %b exp 0", nonce_overflow); end
    repeat (20) step();
    tests++; if (got_q.size() !== 6) begin fails++; $display("FAIL sr_count got %0d exp 6", got_q.size()); end
    for (int i = 0; i < 6 && i < got_q.size(); i++) begin
      tests++; if (got_q[i] !== exp_q[i]) begin fails++; $display("FAIL sr_byte%0d got %02h exp %02h", i, got_q[i], exp_q[i]); end
    end
  endtask

  initial begin
    reset       = 1'b1;
    req_valid   = 1'b0;
    req_type    = 8'h00;
    req_len     = 8'h00;
    req_payload = '0;
    nonce_valid = 1'b0;
    nonce       = 32'h0;
    tx_busy     = 1'b0;
    test_reset();
    test_info();
    test_nonce();
    test_priority();
    test_invalid_len();
    test_full_pop();
    test_random();
    test_overflow();
    test_stall_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
